// File: rtl/pulse_stretch_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretch_tx_if
// Description : Signal bundle between core logic and the pulse stretcher.
//               The master side (core logic) raises event requests and
//               clears the sticky overflow flag. The slave side
//               (pulse_stretch_tx) returns the stretched output and its
//               status.
// Ports       : pulse_i      master->slave  event request, one per high cycle
//               overflow_clr master->slave  clears sticky overflow_o
//               o            slave->master  stretched output, registered
//               busy         slave->master  stretcher not idle, registered
//               pending_o    slave->master  queued events not yet started
//               overflow_o   slave->master  sticky, an event was dropped
// Parameters  : PENDING_MAX must match the PENDING_MAX of the attached
//               pulse_stretch_tx so that pending_o widths agree.
// Revision    : 1.0 - initial release
// ============================================================================
interface pulse_stretch_tx_if #(
  parameter int PENDING_MAX = 7
);
  localparam int PEND_W = $clog2(PENDING_MAX + 1);

  logic              pulse_i;
  logic              overflow_clr;
  logic              o;
  logic              busy;
  logic [PEND_W-1:0] pending_o;
  logic              overflow_o;

  // Core logic side: issues events, observes status.
  modport master (
    output pulse_i,
    output overflow_clr,
    input  o,
    input  busy,
    input  pending_o,
    input  overflow_o
  );

  // Stretcher side: consumes events, drives the output and status.
  modport slave (
    input  pulse_i,
    input  overflow_clr,
    output o,
    output busy,
    output pending_o,
    output overflow_o
  );
endinterface
`default_nettype wire

// File: rtl/pulse_stretch_tx.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretch_tx
// Description : Transmit-side pulse stretcher. Turns single-cycle internal
//               event pulses into output pulses with a guaranteed minimum
//               high and low width, so that a 2-flop synchronizer plus
//               rising-edge detector on another (possibly slower) clock
//               sees exactly one rising edge per event. Events arriving
//               while a pulse is in flight are queued in a saturating
//               counter; events beyond PENDING_MAX are dropped and flagged
//               in a sticky overflow bit.
// Ports       : clock     in   system clock, all logic on posedge
//               reset_n   in   synchronous active-low reset
//               bus       slave modport of pulse_stretch_tx_if:
//                 pulse_i      in   event request, each high cycle = 1 event
//                 overflow_clr in   clears sticky overflow_o
//                 o            out  stretched output, registered
//                 busy         out  high whenever not IDLE, registered
//                 pending_o    out  queued events not yet started
//                 overflow_o   out  sticky drop flag (set wins over clear)
// Parameters  : HIGH_CYCLES (>=1) output high time per event
//               LOW_CYCLES  (>=1) minimum low time after each high phase
//               PENDING_MAX (>=1) maximum queued events
// Options     : `define PULSE_STRETCH_TOGGLE_EN selects toggle encoding:
//               each started event inverts o at HIGH entry and o holds
//               through the LOW phase (for both-edge receivers). Queueing,
//               busy, pending_o and overflow_o are identical in both modes.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretch_tx #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int PENDING_MAX = 7
) (
  input wire                clock,
  input wire                reset_n,
  pulse_stretch_tx_if.slave bus
);

  localparam int PEND_W    = $clog2(PENDING_MAX + 1);
  // One phase counter serves both phases, so it is sized for the longer one.
  localparam int c_CNT_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_CNT_W-1:0] c_HIGH_LAST = c_CNT_W'(HIGH_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_LOW_LAST  = c_CNT_W'(LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0]  c_PEND_MAX  = PEND_W'(PENDING_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t              state_q;
  logic [c_CNT_W-1:0]  cnt_q;
  logic                o_q;
  logic                busy_q;
  logic [PEND_W-1:0]   pend_q;
  logic [PEND_W-1:0]   pend_d;
  logic                ovf_q;
  logic                ovf_d;

  logic                w_low_end;
  logic                w_restart;
  logic                w_inc;
  logic                w_drop;
  logic                w_o_start;
  logic                w_o_fall;

  // --------------------------------------------------------------------------
  // Event bookkeeping
  // --------------------------------------------------------------------------
  always_comb begin
    // Last cycle of the LOW phase: the decision point for the next event.
    w_low_end = (state_q == ST_LOW) && (cnt_q == c_LOW_LAST);

    // A new HIGH phase starts straight from LOW if anything is queued or an
    // event arrives on this very cycle. In the latter case with an empty
    // queue the arriving event is consumed directly: inc and dec cancel.
    w_restart = w_low_end && ((pend_q != '0) || bus.pulse_i);

    // In IDLE an incoming event starts a pulse directly and is never queued.
    w_inc     = bus.pulse_i && (state_q != ST_IDLE);

    // Drop only when the queue is full and nothing is consumed this cycle.
    w_drop    = w_inc && !w_restart && (pend_q == c_PEND_MAX);

    pend_d = pend_q;
    if (w_inc && !w_restart) begin
      if (pend_q != c_PEND_MAX) begin
        pend_d = pend_q + 1'b1;
      end
    end else if (w_restart && !w_inc) begin
      // w_restart without w_inc implies pend_q != 0, so this never wraps.
      pend_d = pend_q - 1'b1;
    end

    // Set wins over clear.
    ovf_d = w_drop | (ovf_q & ~bus.overflow_clr);
  end

  // --------------------------------------------------------------------------
  // Output encoding at the two phase boundaries
  // --------------------------------------------------------------------------
  always_comb begin
`ifdef PULSE_STRETCH_TOGGLE_EN
    // Toggle encoding: each event is one transition, held across both phases.
    w_o_start = ~o_q;
    w_o_fall  = o_q;
`else
    // Pulse encoding: high for the HIGH phase, low for the LOW phase.
    w_o_start = 1'b1;
    w_o_fall  = 1'b0;
`endif
  end

  // --------------------------------------------------------------------------
  // State machine with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      o_q     <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;

      case (state_q)
        ST_IDLE: begin
          if (bus.pulse_i) begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
            o_q     <= w_o_start;
            busy_q  <= 1'b1;
          end
        end

        ST_HIGH: begin
          if (cnt_q == c_HIGH_LAST) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            o_q     <= w_o_fall;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end

        ST_LOW: begin
          if (w_low_end) begin
            cnt_q <= '0;
            if (w_restart) begin
              // Back-to-back: no IDLE cycle in between.
              state_q <= ST_HIGH;
              o_q     <= w_o_start;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          o_q     <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o          = o_q;
  assign bus.busy       = busy_q;
  assign bus.pending_o  = pend_q;
  assign bus.overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretch_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pulse_stretch_tx
// Description : Self-checking bench for pulse_stretch_tx with
//               HIGH_CYCLES=4, LOW_CYCLES=4, PENDING_MAX=3. A window-level
//               reference model (one position counter over the whole
//               HIGH+LOW event window plus a queue count) predicts every
//               output after each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_stretch_tx;

  localparam int H    = 4;
  localparam int L    = 4;
  localparam int PMAX = 3;
  localparam int WIN  = H + L;
`ifdef PULSE_STRETCH_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  pulse_stretch_tx_if #(.PENDING_MAX(PMAX)) bus ();

  pulse_stretch_tx #(
    .HIGH_CYCLES (H),
    .LOW_CYCLES  (L),
    .PENDING_MAX (PMAX)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [4:0] dut_vec;
  assign dut_vec = {bus.o, bus.busy, bus.pending_o, bus.overflow_o};

  int checks = 0;
  int errors = 0;

  // Reference model: m_t is the position inside the current event window
  // (0..WIN-1, -1 when idle); first H positions are the high part.
  int m_t    = -1;
  int m_pend = 0;
  bit m_ovf  = 1'b0;
  bit m_o    = 1'b0;

  function automatic logic [4:0] exp_vec();
    logic eo;
    eo = TOG ? m_o : ((m_t >= 0) && (m_t < H));
    return {eo, (m_t >= 0), 2'(m_pend), m_ovf};
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, return #1 later.
  task automatic drive(input logic p, input logic clr, input logic rn);
    bit drop;
    bus.pulse_i      = p;
    bus.overflow_clr = clr;
    reset_n          = rn;
    @(posedge clock);
    drop = 1'b0;
    if (!rn) begin
      m_t = -1; m_pend = 0; m_ovf = 1'b0; m_o = 1'b0;
    end else begin
      if (m_t < 0) begin
        if (p) begin m_t = 0; m_o = !m_o; end
      end else if (m_t == WIN - 1) begin
        if (m_pend > 0 || p) begin
          m_t = 0; m_o = !m_o;
          if (!p) m_pend = m_pend - 1;
        end else begin
          m_t = -1;
        end
      end else begin
        m_t = m_t + 1;
        if (p) begin
          if (m_pend == PMAX) drop = 1'b1;
          else m_pend = m_pend + 1;
        end
      end
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    #1;
    bus.pulse_i      = 1'b0;
    bus.overflow_clr = 1'b0;
    reset_n          = 1'b1;
  endtask

  task automatic settle();
    for (int i = 0; i < WIN * (PMAX + 2); i++) drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== 5'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: got %b want %b", i, dut_vec, 5'b0);
      end
    end
  endtask

  task automatic test_single();
    int hi_cnt, busy_cnt, ev_cnt;
    logic prev;
    settle();
    prev = bus.o; hi_cnt = 0; busy_cnt = 0; ev_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      drive(i == 0, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL single cyc%0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (TOG ? (bus.o !== prev) : (bus.o && !prev)) ev_cnt++;
      if (bus.o) hi_cnt++;
      if (bus.busy) busy_cnt++;
      prev = bus.o;
    end
    checks++;
    if (ev_cnt != 1) begin errors++; $display("FAIL single_events: got %0d want 1", ev_cnt); end
    checks++;
    if (hi_cnt != (TOG ? 12 : H)) begin
      errors++; $display("FAIL single_high_width: got %0d want %0d", hi_cnt, TOG ? 12 : H);
    end
    checks++;
    if (busy_cnt != WIN) begin errors++; $display("FAIL single_busy_width: got %0d want %0d", busy_cnt, WIN); end
  endtask

  task automatic test_queue();
    int ev_idx [4];
    int ev_cnt, busy_cnt, max_pend;
    logic prev;
    settle();
    prev = bus.o; ev_cnt = 0; busy_cnt = 0; max_pend = 0;
    for (int k = 0; k < 4; k++) ev_idx[k] = -1;
    for (int i = 0; i < 32; i++) begin
      drive(i < 3, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL queue cyc%0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (TOG ? (bus.o !== prev) : (bus.o && !prev)) begin
        if (ev_cnt < 4) ev_idx[ev_cnt] = i;
        ev_cnt++;
      end
      if (bus.busy) busy_cnt++;
      if (int'(bus.pending_o) > max_pend) max_pend = int'(bus.pending_o);
      prev = bus.o;
    end
    checks++;
    if (ev_cnt != 3) begin errors++; $display("FAIL queue_events: got %0d want 3", ev_cnt); end
    checks++;
    if (ev_idx[1] - ev_idx[0] != WIN || ev_idx[2] - ev_idx[1] != WIN) begin
      errors++;
      $display("FAIL queue_period: got starts %0d,%0d,%0d want spacing %0d", ev_idx[0], ev_idx[1], ev_idx[2], WIN);
    end
    checks++;
    if (max_pend != 2) begin errors++; $display("FAIL queue_max_pending: got %0d want 2", max_pend); end
    checks++;
    if (busy_cnt != 3 * WIN) begin errors++; $display("FAIL queue_busy: got %0d want %0d", busy_cnt, 3 * WIN); end
    checks++;
    if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL queue_overflow: got %b want 0", bus.overflow_o); end
  endtask

  task automatic test_overflow();
    int ev_cnt;
    logic prev;
    settle();
    prev = bus.o; ev_cnt = 0;
    for (int i = 0; i < 44; i++) begin
      drive(i < 6, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL overflow cyc%0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (TOG ? (bus.o !== prev) : (bus.o && !prev)) ev_cnt++;
      prev = bus.o;
    end
    checks++;
    if (ev_cnt != PMAX + 1) begin errors++; $display("FAIL overflow_events: got %0d want %0d", ev_cnt, PMAX + 1); end
    checks++;
    if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b want 1", bus.overflow_o); end
    drive(1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b want 0", bus.overflow_o); end
    // Fill the queue, then drop and clear on the same cycle: set wins.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if (dut_vec !== exp_vec() || bus.overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set_wins: got %b want %b", dut_vec, exp_vec());
    end
    drive(1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL overflow_clear2: got %b want 0", bus.overflow_o); end
  endtask

  task automatic test_simul_incdec();
    settle();
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2 * WIN && m_t != WIN - 1; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL incdec_wait cyc%0d: got %b want %b", i, dut_vec, exp_vec());
      end
    end
    // Pulse on the last LOW cycle with one event queued.
    drive(1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.pending_o !== 2'd1 || bus.busy !== 1'b1 || bus.o !== (TOG ? 1'b0 : 1'b1)) begin
      errors++;
      $display("FAIL incdec_restart: got o=%b busy=%b pend=%0d want o=%b busy=1 pend=1",
               bus.o, bus.busy, bus.pending_o, TOG ? 1'b0 : 1'b1);
    end
    for (int i = 0; i < 3 * WIN; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL incdec_drain cyc%0d: got %b want %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    settle();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.pending_o !== 2'd2 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL midreset_pre: got pend=%0d busy=%b want pend=2 busy=1", bus.pending_o, bus.busy);
    end
    drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (dut_vec !== 5'b0) begin errors++; $display("FAIL midreset_at: got %b want %b", dut_vec, 5'b0); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== 5'b0) begin errors++; $display("FAIL midreset_idle cyc%0d: got %b want %b", i, dut_vec, 5'b0); end
    end
    for (int i = 0; i < WIN + 2; i++) begin
      drive(i == 0, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL midreset_restart cyc%0d: got %b want %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic p, clr, rn;
    settle();
    for (int i = 0; i < 600; i++) begin
      p   = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 15) == 0);
      rn  = ($urandom_range(0, 127) != 0);
      drive(p, clr, rn);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc%0d: got %b want %b (p=%b clr=%b rn=%b)", i, dut_vec, exp_vec(), p, clr, rn);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.pulse_i      = 1'b0;
    bus.overflow_clr = 1'b0;
    test_reset();
    test_single();
    test_queue();
    test_overflow();
    test_simul_incdec();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
